// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/reqN_ready        request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op      operands and op code (00 add, 01 sub, 10 and, 11 or)
//   rspN_valid/rspN_ready        response handshake for requester N
//   rsp_result, rsp_zero         captured ALU result and zero flag (shared by both ports)
//   alu_a, alu_b, alu_control    operands and op code driven to the shared ALU
//   alu_result, alu_zero         combinational ALU outputs
//
// Flow: IDLE (arbitrate and accept) -> EXEC (capture ALU result) -> RESP (hold
// the result until the granted requester takes it). Ties are broken round-robin.
module alu_arbiter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [width-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [1:0]       alu_control,
  input  logic [width-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   a_q, a_d;
  logic [width-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [width-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               win;

  always_comb begin
    // Tie goes to the requester not granted last; otherwise the lone requester.
    win = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    zero_d     = zero_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low for the whole time reset is held.
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = ~win;
          req1_ready = win;
          a_d        = win ? req1_a  : req0_a;
          b_d        = win ? req1_b  : req0_b;
          op_d       = win ? req1_op : req0_op;
          gnt_d      = win;
          last_d     = win;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;

endmodule
